// File: rtl/nano_cpu_if.sv
// Memory port of nano_cpu: one shared instruction/data port against a 256 x 16 memory
// that is read combinationally and written on the rising edge.
interface nano_cpu_if;
  logic [7:0]  address;
  logic [15:0] dataR;
  logic [15:0] dataW;
  logic        ce;
  logic        we;

  modport master (
    output address,
    output dataW,
    output ce,
    output we,
    input  dataR
  );

  modport slave (
    input  address,
    input  dataW,
    input  ce,
    input  we,
    output dataR
  );
endinterface

// File: rtl/nano_cpu.sv
// nano_cpu: multi-cycle 16-bit load/store core (FETCH, DECODE, EXEC), four registers, 8-bit PC.
// Optional feature macro NANOCPU_EXT_ALU_EN adds AND (opcode 8) and OR (opcode 9).
module nano_cpu (
  input  logic       ck,
  input  logic       rst,
  nano_cpu_if.master bus
);

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

  localparam logic [3:0] OpLd   = 4'h0;
  localparam logic [3:0] OpSt   = 4'h1;
  localparam logic [3:0] OpJmp  = 4'h2;
  localparam logic [3:0] OpBrnz = 4'h3;
  localparam logic [3:0] OpXor  = 4'h4;
  localparam logic [3:0] OpSub  = 4'h5;
  localparam logic [3:0] OpAdd  = 4'h6;
  localparam logic [3:0] OpLess = 4'h7;
  localparam logic [3:0] OpEnd  = 4'hF;
`ifdef NANOCPU_EXT_ALU_EN
  localparam logic [3:0] OpAnd  = 4'h8;
  localparam logic [3:0] OpOr   = 4'h9;
`endif

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] rf_q [4];
  logic [15:0] rf_d [4];

  logic [3:0]  op;
  logic [7:0]  fld_a;
  logic [1:0]  fld_t, fld_s1, fld_s2;
  logic        unused_ir;

  // Register fields are 4 bits but only the low two select a register.
  assign op        = ir_q[15:12];
  assign fld_a     = ir_q[11:4];
  assign fld_t     = ir_q[9:8];
  assign fld_s1    = ir_q[5:4];
  assign fld_s2    = ir_q[1:0];
  assign unused_ir = ^ir_q[3:2];

  logic [15:0] op_a, op_b, alu_res;
  logic        alu_wr;

  always_comb begin
    op_a    = rf_q[fld_s1];
    op_b    = rf_q[fld_s2];
    alu_res = '0;
    alu_wr  = 1'b0;
    case (op)
      OpXor:  begin alu_res = op_a ^ op_b; alu_wr = 1'b1; end
      OpSub:  begin alu_res = op_a - op_b; alu_wr = 1'b1; end
      OpAdd:  begin alu_res = op_a + op_b; alu_wr = 1'b1; end
      OpLess: begin alu_res = {15'd0, op_a < op_b}; alu_wr = 1'b1; end
`ifdef NANOCPU_EXT_ALU_EN
      OpAnd:  begin alu_res = op_a & op_b; alu_wr = 1'b1; end
      OpOr:   begin alu_res = op_a | op_b; alu_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    case (state_q)
      StFetch: begin
        ir_d    = bus.dataR;
        pc_d    = pc_q + 8'd1;
        state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        case (op)
          OpLd:    rf_d[fld_s2] = bus.dataR;
          OpJmp:   pc_d = fld_a;
          OpBrnz:  if (rf_q[fld_s2] != 16'd0) pc_d = fld_a;
          OpEnd:   state_d = StHalt;
          default: if (alu_wr) rf_d[fld_t] = alu_res;
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // The write strobe is masked by rst so a store whose EXEC edge coincides with reset never lands.
  always_comb begin
    bus.address = pc_q;
    bus.ce      = 1'b0;
    bus.we      = 1'b0;
    bus.dataW   = '0;
    case (state_q)
      StFetch: bus.ce = 1'b1;
      StExec: begin
        if (op == OpLd) begin
          bus.address = fld_a;
          bus.ce      = 1'b1;
        end else if (op == OpSt) begin
          bus.address = fld_a;
          bus.ce      = 1'b1;
          bus.we      = !rst;
          bus.dataW   = rst ? 16'd0 : rf_q[fld_s2];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      rf_q    <= '{default: 16'd0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_nano_cpu.sv
// Self-checking bench for nano_cpu: reset, ALU vector table, directed programs and random
// programs compared against an instruction-level reference model.
module tb_nano_cpu;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic ld_en = 1'b0;
  always #5 ck = ~ck;

  nano_cpu_if bus ();

  nano_cpu dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem   [256];
  logic [15:0] img   [256];
  logic [15:0] m_mem [256];

  assign bus.dataR = mem[bus.address];

  always @(posedge ck) begin
    if (ld_en) mem <= img;
    else if (bus.we) mem[bus.address] <= bus.dataW;
  end

  int total = 0;
  int bad = 0;
  int viol = 0;

  // Bus rules that must hold on every cycle.
  always @(negedge ck) begin
    if (!bus.we && bus.dataW !== 16'h0) viol++;
    if (bus.we && !bus.ce) viol++;
    if (rst && bus.we) viol++;
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction-level model: executes the program in m_mem until END or a step bound.
  task automatic model_run(output int n, output logic [7:0] pc_out, output bit halted);
    logic [15:0] r [4];
    logic [15:0] ir, x, y;
    logic [7:0]  pc, a;
    r = '{default: 16'h0};
    pc = 8'h0;
    n = 0;
    halted = 1'b0;
    while (!halted && n < 1000) begin
      ir = m_mem[pc];
      pc = pc + 8'd1;
      n++;
      a = ir[11:4];
      x = r[ir[5:4]];
      y = r[ir[1:0]];
      case (ir[15:12])
        4'h0: r[ir[1:0]] = m_mem[a];
        4'h1: m_mem[a] = r[ir[1:0]];
        4'h2: pc = a;
        4'h3: if (r[ir[1:0]] != 16'h0) pc = a;
        4'h4: r[ir[9:8]] = x ^ y;
        4'h5: r[ir[9:8]] = x - y;
        4'h6: r[ir[9:8]] = x + y;
        4'h7: r[ir[9:8]] = (x < y) ? 16'd1 : 16'd0;
`ifdef NANOCPU_EXT_ALU_EN
        4'h8: r[ir[9:8]] = x & y;
        4'h9: r[ir[9:8]] = x | y;
`endif
        4'hF: halted = 1'b1;
        default: ;
      endcase
    end
    pc_out = pc;
  endtask

  // Loads img, runs the DUT for the expected cycle count and compares against the model.
  task automatic run_prog(input string name, input int cycles_req);
    int n, cyc, idx;
    bit halted, found;
    logic [7:0] exp_pc;
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    model_run(n, exp_pc, halted);
    if (!halted) begin
      total++;
      bad++;
      $display("FAIL %s_model_halt: actual=running required=halted", name);
    end
    cyc = (cycles_req > 0) ? cycles_req : 3 * n;
    rst = 1'b1;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
    rst = 1'b0;
    repeat (cyc - 3) step();
    check({name, "_end_fetch_ce"}, {31'd0, bus.ce}, 32'd1);
    repeat (3) step();
    check({name, "_halt_ce"}, {31'd0, bus.ce}, 32'd0);
    check({name, "_halt_pc"}, {24'd0, bus.address}, {24'd0, exp_pc});
    repeat (3) step();
    check({name, "_stay"}, {22'd0, bus.ce, bus.we, bus.address}, {24'd0, exp_pc});
    idx = 0;
    found = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (!found && mem[i] !== m_mem[i]) begin
        idx = i;
        found = 1'b1;
      end
    end
    check($sformatf("%s_mem[%0d]", name, idx), {16'd0, mem[idx]}, {16'd0, m_mem[idx]});
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h0;
  endtask

  typedef struct {
    logic [15:0] insn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[$];

  initial begin
    logic [7:0] tgt, len;
    logic [15:0] w;
    int k;

    // ALU table: R0=a, R1=b, R2=0xBEEF, then insn (t=2, s1=0, s2=1) and store R2.
    vecs.push_back('{16'h6201, 16'hFFFF, 16'h0001, 16'h0000});
    vecs.push_back('{16'h5201, 16'h0000, 16'h0001, 16'hFFFF});
    vecs.push_back('{16'h7201, 16'h1234, 16'h1234, 16'h0000});
    vecs.push_back('{16'h7201, 16'h0003, 16'h0005, 16'h0001});
    vecs.push_back('{16'h7201, 16'h8000, 16'h7FFF, 16'h0000});
    vecs.push_back('{16'h4201, 16'hF0F0, 16'hFF00, 16'h0FF0});
    vecs.push_back('{16'h6E4D, 16'h1234, 16'h4321, 16'h5555});
    vecs.push_back('{16'hE201, 16'h1111, 16'h2222, 16'hBEEF});
`ifdef NANOCPU_EXT_ALU_EN
    vecs.push_back('{16'h8201, 16'h0F0F, 16'h00FF, 16'h000F});
    vecs.push_back('{16'h9201, 16'h0F0F, 16'h00FF, 16'h0FFF});
`else
    vecs.push_back('{16'h8201, 16'h0F0F, 16'h00FF, 16'hBEEF});
    vecs.push_back('{16'h9201, 16'h0F0F, 16'h00FF, 16'hBEEF});
`endif

    // Reset state, then the first fetch must come from mem[0] (an END here).
    clear_img();
    img[0] = 16'hF000;
    rst = 1'b1;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
    check("reset_out", {bus.address, bus.ce, bus.we, bus.dataW}, {8'h00, 1'b1, 1'b0, 16'h0});
    rst = 1'b0;
    repeat (3) step();
    check("first_fetch", {23'd0, bus.ce, bus.address}, {23'd0, 1'b0, 8'h01});

    foreach (vecs[i]) begin
      clear_img();
      img[0] = 16'h0C80;
      img[1] = 16'h0C91;
      img[2] = 16'h0CB2;
      img[3] = vecs[i].insn;
      img[4] = 16'h1CA2;
      img[5] = 16'hF000;
      img[200] = vecs[i].a;
      img[201] = vecs[i].b;
      img[203] = 16'hBEEF;
      run_prog($sformatf("alu%0d", i), 18);
      check($sformatf("alu%0d_result", i), {16'd0, mem[202]}, {16'd0, vecs[i].exp});
    end

    // Full program.
    clear_img();
    img[0] = 16'h01E0; img[1] = 16'h01F1; img[2] = 16'h0202; img[3] = 16'h0213;
    img[4] = 16'h6003; img[5] = 16'h5101; img[6] = 16'h4300; img[7] = 16'h7210;
    img[8] = 16'h10F0; img[9] = 16'h1101; img[10] = 16'h1112; img[11] = 16'h3FF2;
    img[20] = 16'hF000; img[255] = 16'h2140;
    img[30] = 16'h1111; img[31] = 16'h2222; img[32] = 16'h3333; img[33] = 16'h4444;
    run_prog("full", 42);
    check("full_m15", {16'd0, mem[15]}, 32'h5555);
    check("full_m16", {16'd0, mem[16]}, 32'h3333);
    check("full_m17", {16'd0, mem[17]}, 32'h0001);
    check("full_r3", {16'd0, dut.rf_q[3]}, 32'h0);
    check("full_pc", {24'd0, bus.address}, 32'h15);

    // Branch on zero register falls through.
    clear_img();
    img[0] = 16'h0C80; img[1] = 16'h3400; img[2] = 16'hF000; img[8'h40] = 16'hF000;
    run_prog("br_nt", 9);
    check("br_nt_pc", {24'd0, bus.address}, 32'h03);

    // Branch to 0xFF, fall-through there wraps PC to 0x00.
    clear_img();
    img[0] = 16'h2500; img[8'h50] = 16'h3601; img[8'h51] = 16'h0C81; img[8'h52] = 16'h2FF0;
    img[255] = 16'hE000; img[8'h60] = 16'hF000; img[200] = 16'h0005;
    run_prog("wrap", 24);
    check("wrap_pc", {24'd0, bus.address}, 32'h61);

    // Reset during EXEC of a store.
    clear_img();
    img[0] = 16'h0C80; img[1] = 16'h1C90; img[200] = 16'h1234;
    rst = 1'b1;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
    rst = 1'b0;
    repeat (5) step();
    check("st_exec_we", {23'd0, bus.we, bus.address}, {23'd0, 1'b1, 8'hC9});
    rst = 1'b1;
    #1;
    check("st_rst_we", {31'd0, bus.we}, 32'd0);
    step();
    rst = 1'b0;
    check("st_rst_mem", {16'd0, mem[201]}, 32'h0);
    check("st_rst_out", {23'd0, bus.ce, bus.address}, {23'd0, 1'b1, 8'h00});
    check("st_rst_r0", {16'd0, dut.rf_q[0]}, 32'h0);

    // Random forward-only programs; final registers dumped to 0x90..0x93.
    for (int p = 0; p < 40; p++) begin
      clear_img();
      for (int i = 8'h80; i < 8'h90; i++) img[i] = 16'($urandom);
      len = 8'($urandom_range(6, 20));
      for (int i = 0; i < int'(len); i++) begin
        k = $urandom_range(0, 9);
        tgt = 8'(i + 1 + $urandom_range(0, 3));
        if (tgt > len) tgt = len;
        w = 16'($urandom);
        case (k)
          0, 1: img[i] = {4'h0, 4'h8, w[11:0]};
          2:    img[i] = {4'h1, 4'h8, w[11:0]};
          3:    img[i] = {4'h3, tgt, w[3:0]};
          4:    img[i] = {4'h2, tgt, w[3:0]};
          5, 6, 7, 8: img[i] = {4'(4 + $urandom_range(0, 3)), w[11:0]};
          default: img[i] = {4'(8 + $urandom_range(0, 6)), w[11:0]};
        endcase
      end
      for (int j = 0; j < 4; j++) img[int'(len) + j] = {4'h1, 4'h9, 4'(j), 4'(j)};
      img[int'(len) + 4] = 16'hF000;
      run_prog($sformatf("rnd%0d", p), 0);
    end

    check("bus_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
